// File: rtl/cl_axi_trace_mon_if.sv
// cl_axi_trace_mon_if: the AXI4 handshake, ID, address and response signals snooped by the trace monitor.
interface cl_axi_trace_mon_if #(
    parameter int ID_W   = 16,
    parameter int ADDR_W = 64
);
    logic              awvalid, awready;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic              arvalid, arready;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic              bvalid, bready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              rvalid, rready, rlast;
    logic [ID_W-1:0]   rid;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awready, awid, awaddr, awlen,
        output arvalid, arready, arid, araddr, arlen,
        output bvalid, bready, bid, bresp,
        output rvalid, rready, rlast, rid, rresp
    );

    modport slave (
        input awvalid, awready, awid, awaddr, awlen,
        input arvalid, arready, arid, araddr, arlen,
        input bvalid, bready, bid, bresp,
        input rvalid, rready, rlast, rid, rresp
    );
endinterface

// File: rtl/cl_axi_trace_mon.sv
// cl_axi_trace_mon: passive AXI4 tracer into a circular RAM with trigger, post-trigger depth and outstanding counters.
// Define CL_AXI_TRACE_MON_TS_EN to append a free-running timestamp to every entry.
module cl_axi_trace_mon #(
    parameter int ID_W   = 16,
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 512,
    parameter int TS_W   = 32,
    parameter int OUT_W  = 8,
    localparam int PW    = $clog2(DEPTH),
`ifdef CL_AXI_TRACE_MON_TS_EN
    localparam int ENTRY_W = 2 + ID_W + 8 + ADDR_W + TS_W
`else
    localparam int ENTRY_W = 2 + ID_W + 8 + ADDR_W
`endif
) (
    input  logic                 aclk_i,
    input  logic                 areset_i,
    cl_axi_trace_mon_if.slave    mon,
    input  logic                 arm_i,
    input  logic                 trig_force_i,
    input  logic [3:0]           trig_type_en_i,
    input  logic [ADDR_W-1:0]    trig_addr_i,
    input  logic [ADDR_W-1:0]    trig_mask_i,
    input  logic [PW-1:0]        post_cnt_i,
    input  logic [PW-1:0]        rd_addr_i,
    output logic [ENTRY_W-1:0]   rd_data_o,
    output logic [1:0]           state_o,
    output logic [PW-1:0]        wr_ptr_o,
    output logic [PW-1:0]        trig_ptr_o,
    output logic                 wrapped_o,
    output logic [15:0]          drop_cnt_o,
    output logic [OUT_W-1:0]     wr_out_o,
    output logic [OUT_W-1:0]     rd_out_o,
    output logic                 cnt_err_o
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_POST  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1) begin : g_bad_cfg
        $error("cl_axi_trace_mon: DEPTH must be a power of two >= 4 and TS_W >= 1");
    end

    logic [1:0]         state_q;
    logic [PW-1:0]      wr_ptr_q, trig_ptr_q, rem_q;
    logic               wrapped_q, cnt_err_q;
    logic [15:0]        drop_cnt_q, drop_d;
    logic [OUT_W-1:0]   wr_out_q, rd_out_q;
    logic [ENTRY_W-1:0] rd_data_q, entry;
    logic [ENTRY_W-1:0] mem [DEPTH];

    logic               ev_aw, ev_ar, ev_b, ev_r, capture, hit;
    logic [2:0]         n_ev;
    logic [16:0]        drop_sum;
    logic [1:0]         ev_type;
    logic [ID_W-1:0]    ev_id;
    logic [7:0]         ev_len;
    logic [ADDR_W-1:0]  ev_payload;

    assign ev_aw = mon.awvalid & mon.awready;
    assign ev_ar = mon.arvalid & mon.arready;
    assign ev_b  = mon.bvalid & mon.bready;
    assign ev_r  = mon.rvalid & mon.rready & mon.rlast;
    assign n_ev  = {2'b0, ev_aw} + {2'b0, ev_ar} + {2'b0, ev_b} + {2'b0, ev_r};

    // Only the highest-priority event of the cycle is recorded
    always_comb begin
        ev_type    = 2'd3;
        ev_id      = mon.rid;
        ev_len     = '0;
        ev_payload = {{(ADDR_W-2){1'b0}}, mon.rresp};
        if (ev_aw) begin
            ev_type    = 2'd0;
            ev_id      = mon.awid;
            ev_len     = mon.awlen;
            ev_payload = mon.awaddr;
        end else if (ev_ar) begin
            ev_type    = 2'd1;
            ev_id      = mon.arid;
            ev_len     = mon.arlen;
            ev_payload = mon.araddr;
        end else if (ev_b) begin
            ev_type    = 2'd2;
            ev_id      = mon.bid;
            ev_len     = '0;
            ev_payload = {{(ADDR_W-2){1'b0}}, mon.bresp};
        end
    end

    assign capture  = ~arm_i & (n_ev != 3'd0) & ((state_q == S_ARMED) | (state_q == S_POST));
    assign hit      = capture & (state_q == S_ARMED) & trig_type_en_i[ev_type]
                    & (((ev_payload ^ trig_addr_i) & trig_mask_i) == '0);
    assign drop_sum = {1'b0, drop_cnt_q} + 17'(n_ev) - 17'd1;
    assign drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

`ifdef CL_AXI_TRACE_MON_TS_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) ts_q <= '0;
        else          ts_q <= ts_q + 1'b1;
    end

    assign entry = {ts_q, ev_payload, ev_len, ev_id, ev_type};
`else
    assign entry = {ev_payload, ev_len, ev_id, ev_type};
`endif

    always_ff @(posedge aclk_i) begin
        if (capture) mem[wr_ptr_q] <= entry;
    end

    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            trig_ptr_q <= '0;
            rem_q      <= '0;
            wrapped_q  <= 1'b0;
            drop_cnt_q <= '0;
            rd_data_q  <= '0;
        end else begin
            rd_data_q <= mem[rd_addr_i];
            if (arm_i) begin
                state_q    <= S_ARMED;
                wr_ptr_q   <= '0;
                trig_ptr_q <= '0;
                wrapped_q  <= 1'b0;
                drop_cnt_q <= '0;
            end else begin
                if (capture) begin
                    wr_ptr_q   <= wr_ptr_q + 1'b1;
                    drop_cnt_q <= drop_d;
                    if (wr_ptr_q == PW'(DEPTH - 1)) wrapped_q <= 1'b1;
                end
                case (state_q)
                    // A qualifying event wins over a force; both latch the current write index
                    S_ARMED: if (hit || trig_force_i) begin
                        trig_ptr_q <= wr_ptr_q;
                        rem_q      <= post_cnt_i;
                        state_q    <= (post_cnt_i == '0) ? S_DONE : S_POST;
                    end
                    S_POST: if (capture) begin
                        rem_q <= rem_q - PW'(1);
                        if (rem_q == PW'(1)) state_q <= S_DONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Outstanding counters track the bus regardless of capture state
    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            wr_out_q  <= '0;
            rd_out_q  <= '0;
            cnt_err_q <= 1'b0;
        end else begin
            if (ev_aw && !ev_b) begin
                if (&wr_out_q) cnt_err_q <= 1'b1;
                else           wr_out_q  <= wr_out_q + 1'b1;
            end else if (ev_b && !ev_aw) begin
                if (wr_out_q == '0) cnt_err_q <= 1'b1;
                else                wr_out_q  <= wr_out_q - 1'b1;
            end
            if (ev_ar && !ev_r) begin
                if (&rd_out_q) cnt_err_q <= 1'b1;
                else           rd_out_q  <= rd_out_q + 1'b1;
            end else if (ev_r && !ev_ar) begin
                if (rd_out_q == '0) cnt_err_q <= 1'b1;
                else                rd_out_q  <= rd_out_q - 1'b1;
            end
        end
    end

    assign rd_data_o  = rd_data_q;
    assign state_o    = state_q;
    assign wr_ptr_o   = wr_ptr_q;
    assign trig_ptr_o = trig_ptr_q;
    assign wrapped_o  = wrapped_q;
    assign drop_cnt_o = drop_cnt_q;
    assign wr_out_o   = wr_out_q;
    assign rd_out_o   = rd_out_q;
    assign cnt_err_o  = cnt_err_q;
endmodule

// File: tb/tb_cl_axi_trace_mon.sv
// tb_cl_axi_trace_mon: directed and random stimulus for cl_axi_trace_mon against a queue-based trace model.
module tb_cl_axi_trace_mon;
    localparam int ID_W    = 8;
    localparam int ADDR_W  = 32;
    localparam int DEPTH   = 8;
    localparam int OUT_W   = 8;
    localparam int PW      = 3;
    localparam int ENTRY_W = 2 + ID_W + 8 + ADDR_W;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    logic arm = 1'b0, trig_force = 1'b0;
    logic [3:0] trig_type_en = '0;
    logic [ADDR_W-1:0] trig_addr = '0, trig_mask = '0;
    logic [PW-1:0] post_cnt = '0, rd_addr = '0;
    logic [ENTRY_W-1:0] rd_data;
    logic [1:0] state;
    logic [PW-1:0] wr_ptr, trig_ptr;
    logic wrapped, cnt_err;
    logic [15:0] drop_cnt;
    logic [OUT_W-1:0] wr_out, rd_out;

    cl_axi_trace_mon_if #(.ID_W(ID_W), .ADDR_W(ADDR_W)) mon_if ();

    cl_axi_trace_mon #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TS_W(32), .OUT_W(OUT_W)) dut (
        .aclk_i(aclk), .areset_i(areset), .mon(mon_if),
        .arm_i(arm), .trig_force_i(trig_force), .trig_type_en_i(trig_type_en),
        .trig_addr_i(trig_addr), .trig_mask_i(trig_mask), .post_cnt_i(post_cnt),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data), .state_o(state), .wr_ptr_o(wr_ptr),
        .trig_ptr_o(trig_ptr), .wrapped_o(wrapped), .drop_cnt_o(drop_cnt),
        .wr_out_o(wr_out), .rd_out_o(rd_out), .cnt_err_o(cnt_err)
    );

    always #5 aclk = ~aclk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_state, m_wp, m_tp, m_rem, m_drop, m_wrout, m_rdout;
    bit m_wrapped, m_err, m_rd_vld;
    logic [63:0] m_mem [DEPTH];
    bit m_vld [DEPTH];
    logic [63:0] m_rd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack(input int t, input int id, input int len, input longint pay);
        return {14'b0, pay[31:0], len[7:0], id[7:0], t[1:0]};
    endfunction

    task automatic clear_inputs();
        mon_if.awvalid = 0; mon_if.awready = 0; mon_if.awid = '0; mon_if.awaddr = '0; mon_if.awlen = '0;
        mon_if.arvalid = 0; mon_if.arready = 0; mon_if.arid = '0; mon_if.araddr = '0; mon_if.arlen = '0;
        mon_if.bvalid = 0; mon_if.bready = 0; mon_if.bid = '0; mon_if.bresp = '0;
        mon_if.rvalid = 0; mon_if.rready = 0; mon_if.rlast = 0; mon_if.rid = '0; mon_if.rresp = '0;
        arm = 0; trig_force = 0;
    endtask

    task automatic model_reset();
        m_state = 0; m_wp = 0; m_tp = 0; m_rem = 0; m_drop = 0;
        m_wrout = 0; m_rdout = 0; m_wrapped = 0; m_err = 0; m_rd_vld = 0; m_rd = '0;
    endtask

    task automatic model_step();
        logic [63:0] q_ent[$];
        int q_typ[$];
        longint q_pay[$];
        bit e_aw, e_ar, e_b, e_r, hit;
        int s, w0;
        e_aw = mon_if.awvalid && mon_if.awready;
        e_ar = mon_if.arvalid && mon_if.arready;
        e_b  = mon_if.bvalid && mon_if.bready;
        e_r  = mon_if.rvalid && mon_if.rready && mon_if.rlast;
        if (e_aw) begin q_ent.push_back(pack(0, int'(mon_if.awid), int'(mon_if.awlen), longint'(mon_if.awaddr))); q_typ.push_back(0); q_pay.push_back(longint'(mon_if.awaddr)); end
        if (e_ar) begin q_ent.push_back(pack(1, int'(mon_if.arid), int'(mon_if.arlen), longint'(mon_if.araddr))); q_typ.push_back(1); q_pay.push_back(longint'(mon_if.araddr)); end
        if (e_b)  begin q_ent.push_back(pack(2, int'(mon_if.bid), 0, longint'(mon_if.bresp))); q_typ.push_back(2); q_pay.push_back(longint'(mon_if.bresp)); end
        if (e_r)  begin q_ent.push_back(pack(3, int'(mon_if.rid), 0, longint'(mon_if.rresp))); q_typ.push_back(3); q_pay.push_back(longint'(mon_if.rresp)); end

        m_rd_vld = m_vld[rd_addr];
        m_rd     = m_mem[rd_addr];

        if (e_aw && !e_b) begin if (m_wrout == 255) m_err = 1; else m_wrout++; end
        else if (e_b && !e_aw) begin if (m_wrout == 0) m_err = 1; else m_wrout--; end
        if (e_ar && !e_r) begin if (m_rdout == 255) m_err = 1; else m_rdout++; end
        else if (e_r && !e_ar) begin if (m_rdout == 0) m_err = 1; else m_rdout--; end

        s = m_state; w0 = m_wp; hit = 0;
        if (arm) begin
            m_state = 1; m_wp = 0; m_tp = 0; m_wrapped = 0; m_drop = 0;
        end else begin
            if ((s == 1 || s == 2) && q_ent.size() > 0) begin
                m_mem[w0] = q_ent[0];
                m_vld[w0] = 1;
                m_drop = m_drop + q_ent.size() - 1;
                if (m_drop > 65535) m_drop = 65535;
                m_wp = (w0 + 1) % DEPTH;
                if (m_wp == 0) m_wrapped = 1;
                hit = (s == 1) && trig_type_en[q_typ[0]] && (((q_pay[0] ^ longint'(trig_addr)) & longint'(trig_mask)) == 0);
                if (s == 2) begin
                    m_rem--;
                    if (m_rem == 0) m_state = 3;
                end
            end
            if (s == 1 && (hit || trig_force)) begin
                m_tp = w0;
                m_rem = int'(post_cnt);
                m_state = (post_cnt == 0) ? 3 : 2;
            end
        end
    endtask

    task automatic check_all();
        chk("state", 64'(state), 64'(m_state));
        chk("wr_ptr", 64'(wr_ptr), 64'(m_wp));
        chk("trig_ptr", 64'(trig_ptr), 64'(m_tp));
        chk("wrapped", 64'(wrapped), 64'(m_wrapped));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        chk("wr_out", 64'(wr_out), 64'(m_wrout));
        chk("rd_out", 64'(rd_out), 64'(m_rdout));
        chk("cnt_err", 64'(cnt_err), 64'(m_err));
        if (m_rd_vld) chk("rd_data", 64'(rd_data), m_rd);
    endtask

    task automatic cyc();
        @(posedge aclk);
        model_step();
        #1 check_all();
        @(negedge aclk);
        clear_inputs();
    endtask

    task automatic do_reset();
        areset = 1;
        #1;
        model_reset();
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_wr_ptr", 64'(wr_ptr), 64'd0);
        chk("rst_trig_ptr", 64'(trig_ptr), 64'd0);
        chk("rst_wrapped", 64'(wrapped), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_wr_out", 64'(wr_out), 64'd0);
        chk("rst_rd_out", 64'(rd_out), 64'd0);
        chk("rst_cnt_err", 64'(cnt_err), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        @(negedge aclk);
        areset = 0;
    endtask

    task automatic set_aw(input int id, input int addr, input int len);
        mon_if.awvalid = 1; mon_if.awready = 1;
        mon_if.awid = id[7:0]; mon_if.awaddr = addr[31:0]; mon_if.awlen = len[7:0];
    endtask

    task automatic set_ar(input int id, input int addr, input int len);
        mon_if.arvalid = 1; mon_if.arready = 1;
        mon_if.arid = id[7:0]; mon_if.araddr = addr[31:0]; mon_if.arlen = len[7:0];
    endtask

    task automatic set_b(input int id, input int resp);
        mon_if.bvalid = 1; mon_if.bready = 1; mon_if.bid = id[7:0]; mon_if.bresp = resp[1:0];
    endtask

    task automatic set_r(input int id, input int resp);
        mon_if.rvalid = 1; mon_if.rready = 1; mon_if.rlast = 1; mon_if.rid = id[7:0]; mon_if.rresp = resp[1:0];
    endtask

    task automatic rand_cycle();
        int a;
        a = int'($urandom_range(0, 3)) * 32'h1000 + int'($urandom_range(0, 1)) * 32'h40;
        mon_if.awvalid = ($urandom_range(0, 9) < 4); mon_if.awready = ($urandom_range(0, 9) < 6);
        mon_if.awid = 8'($urandom); mon_if.awaddr = a[31:0]; mon_if.awlen = 8'($urandom);
        a = int'($urandom_range(0, 3)) * 32'h1000 + int'($urandom_range(0, 1)) * 32'h40;
        mon_if.arvalid = ($urandom_range(0, 9) < 4); mon_if.arready = ($urandom_range(0, 9) < 6);
        mon_if.arid = 8'($urandom); mon_if.araddr = a[31:0]; mon_if.arlen = 8'($urandom);
        mon_if.bvalid = ($urandom_range(0, 9) < 4); mon_if.bready = ($urandom_range(0, 9) < 6);
        mon_if.bid = 8'($urandom); mon_if.bresp = 2'($urandom);
        mon_if.rvalid = ($urandom_range(0, 9) < 5); mon_if.rready = ($urandom_range(0, 9) < 7);
        mon_if.rlast = ($urandom_range(0, 9) < 6); mon_if.rid = 8'($urandom); mon_if.rresp = 2'($urandom);
        rd_addr = PW'($urandom);
        trig_force = ($urandom_range(0, 59) == 0);
        arm = ($urandom_range(0, 39) == 0);
        if (arm) begin
            trig_type_en = 4'($urandom);
            a = int'($urandom_range(0, 3)) * 32'h1000;
            trig_addr = a[31:0];
            case ($urandom_range(0, 2))
                0: trig_mask = 32'hFFFF_F000;
                1: trig_mask = 32'hFFFF_FFFF;
                default: trig_mask = 32'h0;
            endcase
            post_cnt = PW'($urandom);
        end
        cyc();
    endtask

    initial begin
        clear_inputs();
        #3;
        do_reset();

        // Basic AW then B capture and readout
        trig_type_en = 4'b0000;
        arm = 1; cyc();
        set_aw(3, 32'h1000, 7); cyc();
        chk("wr_out_after_aw", 64'(wr_out), 64'd1);
        set_b(3, 0); cyc();
        chk("wr_out_after_b", 64'(wr_out), 64'd0);
        rd_addr = 0; cyc();
        chk("entry0_aw", 64'(rd_data), pack(0, 3, 7, 32'h1000));
        rd_addr = 1; cyc();
        chk("entry1_b", 64'(rd_data), pack(2, 3, 0, 0));

        // Address trigger with two post-trigger entries
        trig_type_en = 4'b0001; trig_addr = 32'h2000; trig_mask = ~32'hFFF; post_cnt = 3'd2;
        arm = 1; cyc();
        set_aw(1, 32'h1000, 0); cyc();
        set_aw(2, 32'h2040, 0); cyc();
        chk("trig_state_post", 64'(state), 64'd2);
        set_aw(3, 32'h3000, 0); cyc();
        set_aw(4, 32'h4000, 0); cyc();
        chk("trig_ptr", 64'(trig_ptr), 64'd1);
        chk("trig_state_done", 64'(state), 64'd3);
        chk("trig_wr_ptr", 64'(wr_ptr), 64'd4);
        set_aw(5, 32'h5000, 0); cyc();
        chk("done_holds_wr_ptr", 64'(wr_ptr), 64'd4);

        // Same-cycle collision
        trig_type_en = 4'b0000;
        arm = 1; cyc();
        set_aw(6, 32'h6000, 1); set_ar(7, 32'h7000, 2); set_b(8, 1); cyc();
        chk("collide_drop", 64'(drop_cnt), 64'd2);
        chk("collide_wr_ptr", 64'(wr_ptr), 64'd1);

        // Forced trigger then reset while in POST
        post_cnt = 3'd3;
        arm = 1; cyc();
        trig_force = 1; cyc();
        chk("force_post", 64'(state), 64'd2);
        @(negedge aclk);
        do_reset();
        set_aw(9, 32'h9000, 0); cyc();
        chk("no_cap_after_rst", 64'(wr_ptr), 64'd0);
        set_b(9, 0); cyc();
        set_b(9, 0); cyc();
        chk("b_underflow_wr_out", 64'(wr_out), 64'd0);
        chk("b_underflow_err", 64'(cnt_err), 64'd1);
        arm = 1; cyc();
        chk("err_sticky_arm", 64'(cnt_err), 64'd1);

        // Wrap with R-last events
        for (int i = 0; i < DEPTH + 2; i++) begin
            set_r(i + 1, (i + 1) % 4); cyc();
        end
        chk("wrap_flag", 64'(wrapped), 64'd1);
        chk("wrap_wr_ptr", 64'(wr_ptr), 64'd2);
        rd_addr = 0; cyc();
        chk("wrap_entry0", 64'(rd_data), pack(3, DEPTH + 1, 0, (DEPTH + 1) % 4));

        for (int n = 0; n < 3000; n++) rand_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cl_axi_trace_mon.md
Name: cl_axi_trace_mon

Overview:
- Parametrised, synthesizable AXI4 transaction tracer; successor to the fixed-width ILA probe wrappers on the DMA PCIS and DDR buses.
- Passively snoops one AXI4 port and records AW/AR/B/R-last handshakes into a circular trace RAM.
- Provides an address/type trigger, a programmable post-trigger depth and outstanding-transaction counters.
- Read back over a simple indexed port from CL register logic, so no JTAG debug bridge is needed.

Parameters:
- ID_W, 16, AXI ID width captured (upper bits truncated).
- ADDR_W, 64, address width.
- DEPTH, 512, trace entries; power of two, >=4.
- TS_W, 32, timestamp width (used only with the optional feature).
- OUT_W, 8, outstanding counter width.

Ports:
- aclk  in  1  clock
- areset  in  1  async reset, active-high
- mon_awvalid/mon_awready  in  1 each  AW handshake
- mon_awid  in  ID_W  AW ID
- mon_awaddr  in  ADDR_W  AW address
- mon_awlen  in  8  AW burst length
- mon_arvalid/mon_arready/mon_arid/mon_araddr/mon_arlen  in  1/1/ID_W/ADDR_W/8  AR channel, same meanings
- mon_bvalid/mon_bready  in  1 each  B handshake
- mon_bid  in  ID_W  B ID
- mon_bresp  in  2  B response
- mon_rvalid/mon_rready/mon_rlast  in  1 each  R handshake and last beat
- mon_rid  in  ID_W  R ID
- mon_rresp  in  2  R response
- arm  in  1  pulse: clear and start capture
- trig_force  in  1  pulse: immediate trigger
- trig_type_en  in  4  qualifying types, bit order {R,B,AR,AW}
- trig_addr  in  ADDR_W  trigger compare value
- trig_mask  in  ADDR_W  trigger compare mask
- post_cnt  in  $clog2(DEPTH)  post-trigger entry count
- rd_addr  in  $clog2(DEPTH)  readout index
- rd_data  out  ENTRY_W  readout entry
- state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
- wr_ptr  out  $clog2(DEPTH)  next write index
- trig_ptr  out  $clog2(DEPTH)  index of the trigger entry
- wrapped  out  1  buffer has wrapped since arm
- drop_cnt  out  16  events lost to same-cycle collision; saturating
- wr_out/rd_out  out  OUT_W each  outstanding writes/reads
- cnt_err  out  1  sticky counter underflow/overflow

Behaviour:
- Reset: all outputs 0, state IDLE; RAM contents undefined.
- Entry layout, LSB first: type[2] (0 AW, 1 AR, 2 B, 3 R), id[ID_W], len[8], payload[ADDR_W], ts[TS_W] (ts only with the optional feature).
  - AW/AR: payload is the address.
  - B/R: payload is {0, resp}; len is 0.
- Event = valid&&ready on a channel; for R, rlast is also required.
- At most one entry written per cycle, priority AW > AR > B > R.
  - Each lower-priority event in the same cycle increments drop_cnt by 1, saturating at 0xFFFF.
- Entries are written only in ARMED and POST; each write advances wr_ptr modulo DEPTH.
  - Wrap from DEPTH-1 to 0 sets wrapped.
- Triggering in ARMED: the written entry is the trigger if trig_type_en[type] is set and ((payload^trig_addr)&trig_mask)==0.
  - On trigger: trig_ptr <= entry index, state -> POST, internal remaining count <= post_cnt.
  - post_cnt==0: state -> DONE instead of POST.
- trig_force in ARMED: trig_ptr <= wr_ptr (the next write index, no entry required), then the same POST/DONE transition.
  - A force coincident with a qualifying event takes the event path.
- POST: each written entry decrements the remaining count; the entry that brings it to 0 is written, and state -> DONE the next cycle.
- DONE: no writes; pointers hold.
- arm in any state: wr_ptr, wrapped, drop_cnt and trig_ptr cleared; state -> ARMED.
  - An event in the arm cycle is not captured.
- Readout: rd_data registered, 1-cycle latency, valid in every state.
  - Read and write to the same index in the same cycle returns the old contents (read-first).
- Outstanding counters always run, independent of state and arm.
  - wr_out: +1 on AW, -1 on B, unchanged if both occur.
  - rd_out: +1 on AR, -1 on R-last, unchanged if both occur.
  - Decrement at 0 or increment at max: counter holds and cnt_err is set (sticky until reset).

Optional Feature:
- CL_AXI_TRACE_MON_TS_EN defined: a TS_W free-running timestamp (cleared by reset, wraps) is stored in each entry; ENTRY_W = 2+ID_W+8+ADDR_W+TS_W.
- Undefined: no timestamp counter; ENTRY_W = 2+ID_W+8+ADDR_W.

Test Plan:
- Reset, then arm; AW id=3 addr=0x1000 len=7; then B id=3 resp=0 -> rd_addr=0 gives type 0/id 3/len 7/addr 0x1000; rd_addr=1 gives type 2; wr_out goes 1 then 0.
- trig_type_en=0001, trig_addr=0x2000, mask=~0xFFF, post_cnt=2; AWs to 0x1000, 0x2040, 0x3000, 0x4000 -> trig_ptr=1, state DONE after the 0x4000 entry, wr_ptr=4.
- AW, AR and B handshakes in one cycle while ARMED -> only the AW entry written, drop_cnt=2.
- DEPTH=4, arm, 6 R-last events -> wrapped=1, wr_ptr=2, index 0 holds the 5th event.
- B with wr_out=0 -> wr_out stays 0, cnt_err=1; a following arm leaves cnt_err=1.
- Assert areset in POST -> state 0, all outputs 0; after deassert, events are not captured until arm.
